serial_min_grp: RTL and testbench
=================================

# serial_min_grp

Streaming reduction block: accepts one `DW`-bit sample per cycle over a valid/ready handshake, groups consecutive samples into groups of `GROUP` (default 3), and emits the minimum of each group plus its position within the group. It is the serial-input counterpart of the parallel three-input compare pipeline. It sits between a sample source that delivers operands one at a time and a downstream min consumer.

## Interface
- `DW`, 8, sample and result width (unsigned).
- `GROUP`, 3, samples per group; legal range 2..16.
- `IW`, `$clog2(GROUP)`, index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  source presents `in_data`.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  DW  sample, unsigned.
- `in_last`  in  1  qualifies with `in_valid`; closes the current group early.
- `out_valid`  out  1  result held in output register.
- `out_ready`  in  1  consumer takes result this cycle.
- `out_min`  out  DW  group minimum.
- `out_idx`  out  IW  position (0-based) of minimum within group.
- `out_cnt`  out  IW+1  number of samples in the group (1..GROUP).

## Operation
- Accept = `in_valid && in_ready`. Transfer out = `out_valid && out_ready`.
- Internal state: sample counter `cnt` (0..GROUP-1), running `run_min`, `run_idx`; output register `out_*`.
- Accept with `cnt == 0`: `run_min <= in_data`, `run_idx <= 0`.
- Accept with `cnt > 0`: update only if `in_data < run_min` (strict). On ties the earlier sample wins.
- Closing accept = accept with `cnt == GROUP-1` or `in_last == 1`. It loads the output register:
  - `out_min` = min(`run_min`, `in_data`), or `in_data` if `cnt == 0`.
  - `out_idx` = matching position.
  - `out_cnt` = `cnt + 1`.
  - `out_valid <= 1`, `cnt <= 0`.
- Non-closing accept: `cnt <= cnt + 1`.
- `in_ready` = `!(cnt == GROUP-1 || in_last) || !out_valid || out_ready`.
  - Non-closing samples are always accepted, even while the output is stalled.
  - Only a closing sample waits for output space.
- Transfer out with no simultaneous closing accept: `out_valid <= 0`.
- Simultaneous transfer out and closing accept: new result replaces old in the same cycle, and `out_valid` stays 1. No bubble, no loss.
- `in_last` with `cnt == 0` gives a single-sample group: `out_cnt = 1`, `out_idx = 0`.
- `in_data` and `in_last` are ignored when `in_valid = 0`.

## Timing
- Reset (sync, takes priority over every other action in the cycle):
  - `cnt = 0`, `run_min = 0`, `run_idx = 0`.
  - `out_valid = 0`, `out_min = 0`, `out_idx = 0`, `out_cnt = 0`.
  - `in_ready = 1` in the cycle after reset.
- Reset mid-group discards the partial group and any unread result. There is no output after reset.
- Latency: `out_valid` rises the cycle after the closing accept.
- Throughput: one sample per cycle sustained when `out_ready = 1`, giving one result every `GROUP` cycles.
- `out_*` must stay stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready`, `in_last` and state. There is no path from `in_valid` to `in_ready`.

## Structure
- Shared package `min_grp_pkg`:
  - defaults `MIN_GRP_DW = 8` and `MIN_GRP_N = 3`;
  - typedef `min_res_t` struct {`min`, `idx`, `cnt`}.
- One sub-module, `min_grp_acc`: counter, running compare and closing detection. It outputs a result struct plus a `close` strobe.
- The top level holds the output register and the handshake logic.
- Compare is unsigned and `DW` wide; no widening needed.

## Test plan
1. GROUP=3, `out_ready = 1`, stream 7, 3, 9 → one cycle after the third accept: `out_min = 3`, `out_idx = 1`, `out_cnt = 3`.
2. Ties: stream 5, 5, 5 → `out_min = 5`, `out_idx = 0`. Then stream 8, 2, 2 → `out_idx = 1`.
3. Early close: `in_last` on the 2nd sample of 200, 100 → `out_min = 100`, `out_idx = 1`, `out_cnt = 2`. Then a lone 0x00 with `in_last` → `out_cnt = 1`, `out_min = 0`.
4. Backpressure: `out_ready = 0`, stream groups {4,6,1} and {9,8,7}.
   - 1st result holds (`out_min = 1`), with `out_*` stable.
   - 2nd group: samples 9 and 8 are accepted; `in_ready = 0` while sample 7 is offered.
   - Raise `out_ready`: 7 is accepted in the same cycle and `out_min` becomes 7 with no `out_valid` gap.
5. Back-to-back streaming: 30 random samples, `out_ready = 1`, `in_valid` held high.
   - Exactly 10 results, each matching a reference min/idx model.
   - `in_ready` never drops.
6. Reset mid-operation: accept 10, 20, assert `rst` for 1 cycle, then stream 50, 40, 60.
   - All outputs are 0 and `out_valid = 0` after reset.
   - Single result: `out_min = 40`, `out_idx = 1`, `out_cnt = 3`.

Source files
------------

// File: rtl/min_grp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : min_grp_pkg
// Purpose  : Shared defaults and result type for the grouped-minimum blocks.
// Revision : 1.0  initial release
// ============================================================================
package min_grp_pkg;

    localparam int MIN_GRP_DW = 8;
    localparam int MIN_GRP_N  = 3;
    localparam int MIN_GRP_IW = $clog2(MIN_GRP_N);

    // Result of one closed group, sized for the default configuration.
    // Blocks built with other widths declare an identically shaped struct
    // and pass it down as a type parameter.
    typedef struct packed {
        logic [MIN_GRP_DW-1:0] min;
        logic [MIN_GRP_IW-1:0] idx;
        logic [MIN_GRP_IW:0]   cnt;
    } min_res_t;

endpackage : min_grp_pkg
`default_nettype wire

// File: rtl/serial_min_grp_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_min_grp_if
// Purpose  : Sample-in / result-out handshake bundle for serial_min_grp.
//            slave  = the reduction block, master = source + consumer side.
// Revision : 1.0  initial release
// ============================================================================
interface serial_min_grp_if #(
    parameter int DW    = 8,
    parameter int GROUP = 3
);
    localparam int IW = $clog2(GROUP);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_min;
    logic [IW-1:0] out_idx;
    logic [IW:0]   out_cnt;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_idx, out_cnt
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_idx, out_cnt
    );

endinterface : serial_min_grp_if
`default_nettype wire

// File: rtl/min_grp_acc.sv
`default_nettype none
// ============================================================================
// Module   : min_grp_acc
// Purpose  : Per-group sample counter and running minimum. Presents the
//            result the group would have if the current sample closed it,
//            together with a close strobe for the output stage.
// Revision : 1.0  initial release
// ============================================================================
module min_grp_acc
    import min_grp_pkg::*;
#(
    parameter int  DW    = MIN_GRP_DW,
    parameter int  GROUP = MIN_GRP_N,
    parameter type RES_T = min_res_t
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          accept,
    input  wire logic [DW-1:0] data,
    input  wire logic          last,
    output logic               at_end,
    output logic               close,
    output RES_T               res
);

    localparam int            IW       = $clog2(GROUP);
    localparam logic [IW-1:0] LAST_POS = IW'(GROUP - 1);

    logic [IW-1:0] cnt;
    logic [IW-1:0] run_idx;
    logic [DW-1:0] run_min;
    logic          take_new;
    logic [DW-1:0] next_min;
    logic [IW-1:0] next_idx;

    // Position GROUP-1 always ends a group; in_last may end it sooner.
    assign at_end = (cnt == LAST_POS);
    assign close  = accept && (at_end || last);

    // Running compare: first sample seeds, later ones replace only when
    // strictly smaller so the earliest of equal values keeps the index.
    always_comb begin
        take_new = (cnt == '0) || (data < run_min);
        next_min = take_new ? data : run_min;
        next_idx = take_new ? cnt  : run_idx;
        res      = '0;
        res.min  = next_min;
        res.idx  = next_idx;
        res.cnt  = (IW+1)'(cnt) + (IW+1)'(1);
    end

    // Counter and running state advance on every accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            run_min <= '0;
            run_idx <= '0;
        end else if (accept) begin
            run_min <= next_min;
            run_idx <= next_idx;
            cnt     <= close ? '0 : cnt + 1'b1;
        end
    end

endmodule : min_grp_acc
`default_nettype wire

// File: rtl/serial_min_grp.sv
`default_nettype none
// ============================================================================
// Module   : serial_min_grp
// Purpose  : Streaming grouped minimum. Accepts one sample per cycle, emits
//            min / index / count of each group through a held output register.
// Revision : 1.0  initial release
// ============================================================================
module serial_min_grp
    import min_grp_pkg::*;
#(
    parameter int DW    = MIN_GRP_DW,
    parameter int GROUP = MIN_GRP_N
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_min_grp_if.slave  bus
);

    localparam int IW = $clog2(GROUP);

    typedef struct packed {
        logic [DW-1:0] min;
        logic [IW-1:0] idx;
        logic [IW:0]   cnt;
    } res_t;

    logic          accept;
    logic          at_end;
    logic          close;
    res_t          res;
    logic          out_valid_reg;
    logic [DW-1:0] out_min_reg;
    logic [IW-1:0] out_idx_reg;
    logic [IW:0]   out_cnt_reg;

    // Only a closing sample needs output space; a transfer in the same
    // cycle frees it, so in_ready never depends on in_valid.
    assign bus.in_ready = !(at_end || bus.in_last) || !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    min_grp_acc #(
        .DW    (DW),
        .GROUP (GROUP),
        .RES_T (res_t)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .data   (bus.in_data),
        .last   (bus.in_last),
        .at_end (at_end),
        .close  (close),
        .res    (res)
    );

    // Output register: a new result overwrites (also during a transfer,
    // keeping out_valid high); otherwise a transfer empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_min_reg   <= '0;
            out_idx_reg   <= '0;
            out_cnt_reg   <= '0;
        end else if (close) begin
            out_valid_reg <= 1'b1;
            out_min_reg   <= res.min;
            out_idx_reg   <= res.idx;
            out_cnt_reg   <= res.cnt;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_min   = out_min_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_cnt   = out_cnt_reg;

endmodule : serial_min_grp
`default_nettype wire

// File: tb/tb_serial_min_grp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_min_grp
// Purpose  : Directed self-checking bench for serial_min_grp (DW=8, GROUP=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_min_grp;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_min_grp_if #(.DW(8), .GROUP(3)) bus ();

    serial_min_grp #(.DW(8), .GROUP(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one sample; returns one cycle after it was accepted.
    task automatic push(input logic [7:0] d, input logic l);
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        #1;
        while (!bus.in_ready && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] m,
                           input logic [1:0] i, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_min"},   32'(bus.out_min),   32'(m));
        chk({tag, "_idx"},   32'(bus.out_idx),   32'(i));
        chk({tag, "_cnt"},   32'(bus.out_cnt),   32'(c));
    endtask

    logic [7:0] samp [30];
    logic [7:0] exp_min;
    logic [1:0] exp_idx;
    int         results;
    int         ready_drops;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk_out("reset", 1'b0, 8'd0, 2'd0, 3'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 1);

        // Basic group
        push(8'd7, 1'b0); push(8'd3, 1'b0); push(8'd9, 1'b0);
        chk_out("basic", 1'b1, 8'd3, 2'd1, 3'd3);

        // Ties keep the earliest index
        push(8'd5, 1'b0); push(8'd5, 1'b0); push(8'd5, 1'b0);
        chk_out("tie_all", 1'b1, 8'd5, 2'd0, 3'd3);
        push(8'd8, 1'b0); push(8'd2, 1'b0); push(8'd2, 1'b0);
        chk_out("tie_late", 1'b1, 8'd2, 2'd1, 3'd3);

        // Early close and single-sample group
        push(8'd200, 1'b0); push(8'd100, 1'b1);
        chk_out("early", 1'b1, 8'd100, 2'd1, 3'd2);
        push(8'd0, 1'b1);
        chk_out("single", 1'b1, 8'd0, 2'd0, 3'd1);
        @(posedge clk); #1;
        chk("drain_valid", 32'(bus.out_valid), 0);

        // Backpressure
        bus.out_ready = 1'b0;
        push(8'd4, 1'b0); push(8'd6, 1'b0); push(8'd1, 1'b0);
        chk_out("bp_first", 1'b1, 8'd1, 2'd2, 3'd3);
        push(8'd9, 1'b0); push(8'd8, 1'b0);
        chk_out("bp_hold", 1'b1, 8'd1, 2'd2, 3'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("bp_in_ready_low", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        chk_out("bp_stable", 1'b1, 8'd1, 2'd2, 3'd3);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk_out("bp_second", 1'b1, 8'd7, 2'd2, 3'd3);
        @(posedge clk); #1;
        chk("bp_drain", 32'(bus.out_valid), 0);

        // Back-to-back streaming against a reference model
        for (int k = 0; k < 30; k++) samp[k] = 8'($urandom_range(0, 255));
        samp[3] = 8'd17; samp[4] = 8'd17; samp[5] = 8'd17;
        results     = 0;
        ready_drops = 0;
        for (int k = 0; k < 30; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = samp[k];
            #1;
            if (!bus.in_ready) ready_drops++;
            @(posedge clk); #1;
            if (bus.out_valid) results++;
            if (k % 3 == 2) begin
                exp_min = samp[k-2];
                exp_idx = 2'd0;
                for (int j = 1; j < 3; j++) begin
                    if (samp[k-2+j] < exp_min) begin
                        exp_min = samp[k-2+j];
                        exp_idx = 2'(j);
                    end
                end
                chk("stream_min", 32'(bus.out_min), 32'(exp_min));
                chk("stream_idx", 32'(bus.out_idx), 32'(exp_idx));
            end
        end
        bus.in_valid = 1'b0;
        chk("stream_results", 32'(results), 10);
        chk("stream_ready_drops", 32'(ready_drops), 0);

        // Reset in the middle of a group
        push(8'd10, 1'b0); push(8'd20, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_out("mid_reset", 1'b0, 8'd0, 2'd0, 3'd0);
        chk("mid_reset_in_ready", 32'(bus.in_ready), 1);
        push(8'd50, 1'b0);
        chk("mid_reset_no_early", 32'(bus.out_valid), 0);
        push(8'd40, 1'b0); push(8'd60, 1'b0);
        chk_out("after_reset", 1'b1, 8'd40, 2'd1, 3'd3);
        @(posedge clk); #1;
        chk("after_reset_single", 32'(bus.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_min_grp
`default_nettype wire
